// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: gray/binary conversion and the default address width.
// Pure combinational; no timing or backpressure of its own.
package fifo_pkg;

  localparam int ADDRSIZE_DEFAULT = 7;
  localparam int GRAY_MAX_W       = 32;

  // Callers zero-extend to GRAY_MAX_W and truncate the result back to their own width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic N-flop clock-domain synchroniser for gray-coded buses, async active-low reset to 0.
// Latency STAGES clk edges; no backpressure, samples every cycle.
module sync_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] sync_q [STAGES];

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/rptr_empty_sync.sv
// Async FIFO read side: synchronises wptr_gray, owns the read pointer, registers empty/almost-empty/level/underflow.
// Flags follow a write after SYNC_STAGES+1 rclk edges and a pop on the same edge; pops while empty are dropped and flagged.
module rptr_empty_sync
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = ADDRSIZE_DEFAULT,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr_gray,
  input  logic                rinc,
  input  logic                rflush,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ruflow
);

  localparam int            PW    = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("rptr_empty_sync: SYNC_STAGES must be >= 2");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDRSIZE)) begin : g_bad_aempty_thresh
    $error("rptr_empty_sync: AEMPTY_THRESH out of range 0..2**ADDRSIZE");
  end

  logic [PW-1:0] w2r_gray;
  logic [PW-1:0] w2r_bin;
  logic          pop;

  logic [PW-1:0] rptr_bin_d,  rptr_bin_q;
  logic [PW-1:0] rptr_gray_d, rptr_gray_q;
  logic [PW-1:0] rlevel_d,    rlevel_q;
  logic          rempty_d,        rempty_q;
  logic          ralmost_empty_d, ralmost_empty_q;
  logic          ruflow_d,        ruflow_q;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_w2r_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .din   (wptr_gray),
    .dout  (w2r_gray)
  );

  // Flags are derived from the next pointer so a pop updates them on the edge it takes effect.
  always_comb begin
    w2r_bin         = PW'(gray2bin(GRAY_MAX_W'(w2r_gray)));
    pop             = rinc & ~rempty_q & ~rflush;
    rptr_bin_d      = rflush ? w2r_bin : rptr_bin_q + PW'(pop);
    rptr_gray_d     = PW'(bin2gray(GRAY_MAX_W'(rptr_bin_d)));
    rempty_d        = (rptr_gray_d == w2r_gray);
    rlevel_d        = w2r_bin - rptr_bin_d;
    ralmost_empty_d = (rlevel_d <= AE_TH);
    ruflow_d        = rinc & rempty_q & ~rflush;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr_bin_q      <= '0;
      rptr_gray_q     <= '0;
      rlevel_q        <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      ruflow_q        <= 1'b0;
    end else begin
      rptr_bin_q      <= rptr_bin_d;
      rptr_gray_q     <= rptr_gray_d;
      rlevel_q        <= rlevel_d;
      rempty_q        <= rempty_d;
      ralmost_empty_q <= ralmost_empty_d;
      ruflow_q        <= ruflow_d;
    end
  end

  assign raddr         = rptr_bin_q[ADDRSIZE-1:0];
  assign rptr_gray     = rptr_gray_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel        = rlevel_q;
  assign ruflow        = ruflow_q;

endmodule

// File: tb/tb_rptr_empty_sync.sv
// Directed bench for rptr_empty_sync: default 7-bit instance plus a 3-bit instance for pointer wrap.
module tb_rptr_empty_sync;

  logic       rclk = 1'b0;
  logic       rrst_n;

  logic [7:0] wptr_gray;
  logic       rinc, rflush;
  logic [6:0] raddr;
  logic [7:0] rptr_gray, rlevel;
  logic       rempty, ralmost_empty, ruflow;

  logic [3:0] wptr3;
  logic       rinc3, rflush3;
  logic [2:0] raddr3;
  logic [3:0] rptr_gray3, rlevel3;
  logic       rempty3, ralmost_empty3, ruflow3;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  rptr_empty_sync dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .wptr_gray     (wptr_gray),
    .rinc          (rinc),
    .rflush        (rflush),
    .raddr         (raddr),
    .rptr_gray     (rptr_gray),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .ruflow        (ruflow)
  );

  rptr_empty_sync #(.ADDRSIZE(3)) dut3 (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .wptr_gray     (wptr3),
    .rinc          (rinc3),
    .rflush        (rflush3),
    .raddr         (raddr3),
    .rptr_gray     (rptr_gray3),
    .rempty        (rempty3),
    .ralmost_empty (ralmost_empty3),
    .rlevel        (rlevel3),
    .ruflow        (ruflow3)
  );

  function automatic logic [7:0] g8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Sample and drive 1 time unit after the active edge.
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    logic [3:0] wbin3, rbin3, prev_g;
    int         lvl;

    rrst_n = 1'b0; wptr_gray = 8'h05; rinc = 1'b0; rflush = 1'b0;
    wptr3 = '0; rinc3 = 1'b0; rflush3 = 1'b0;
    repeat (3) tick();

    check_eq("rst_rempty",  32'(rempty), 1);
    check_eq("rst_raempty", 32'(ralmost_empty), 1);
    check_eq("rst_rlevel",  32'(rlevel), 0);
    check_eq("rst_rgray",   32'(rptr_gray), 0);
    check_eq("rst_ruflow",  32'(ruflow), 0);
    check_eq("rst_raddr",   32'(raddr), 0);

    wptr_gray = 8'h00;
    rrst_n = 1'b1;
    repeat (3) tick();
    check_eq("idle_rempty", 32'(rempty), 1);

    // Write pointer 0 -> 1: empty must clear on exactly the third edge.
    wptr_gray = g8(8'd1);
    tick();
    check_eq("lat_e1_rempty", 32'(rempty), 1);
    tick();
    check_eq("lat_e2_rempty", 32'(rempty), 1);
    tick();
    check_eq("lat_e3_rempty", 32'(rempty), 0);
    check_eq("lat_e3_rlevel", 32'(rlevel), 1);
    check_eq("lat_e3_raempty", 32'(ralmost_empty), 1);

    wptr_gray = g8(8'd10);
    repeat (3) tick();
    check_eq("fill_rlevel",  32'(rlevel), 10);
    check_eq("fill_raempty", 32'(ralmost_empty), 0);
    check_eq("fill_rempty",  32'(rempty), 0);

    rinc = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      lvl = 10 - k;
      check_eq("drain_rlevel",  32'(rlevel), 32'(lvl));
      check_eq("drain_raempty", 32'(ralmost_empty), (lvl <= 4) ? 1 : 0);
      check_eq("drain_rempty",  32'(rempty), (lvl == 0) ? 1 : 0);
      check_eq("drain_raddr",   32'(raddr), 32'(k));
      check_eq("drain_rgray",   32'(rptr_gray), 32'(g8(8'(k))));
    end

    // rinc still high while empty: three rejected pops.
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("uflow_ruflow", 32'(ruflow), 1);
      check_eq("uflow_raddr",  32'(raddr), 10);
      check_eq("uflow_rlevel", 32'(rlevel), 0);
    end
    rinc = 1'b0;
    tick();
    check_eq("uflow_end_ruflow", 32'(ruflow), 0);

    wptr_gray = g8(8'd16);
    repeat (3) tick();
    check_eq("preflush_rlevel", 32'(rlevel), 6);
    rflush = 1'b1; rinc = 1'b1;
    tick();
    rflush = 1'b0; rinc = 1'b0;
    check_eq("flush_rempty", 32'(rempty), 1);
    check_eq("flush_rlevel", 32'(rlevel), 0);
    check_eq("flush_raddr",  32'(raddr), 16);
    check_eq("flush_rgray",  32'(rptr_gray), 32'(g8(8'd16)));
    check_eq("flush_ruflow", 32'(ruflow), 0);

    wptr_gray = g8(8'd20);
    repeat (3) tick();
    check_eq("mid_rlevel", 32'(rlevel), 4);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check_eq("mid_pop_rlevel", 32'(rlevel), 3);
    rrst_n = 1'b0;
    #1;
    check_eq("arst_rempty", 32'(rempty), 1);
    check_eq("arst_rlevel", 32'(rlevel), 0);
    check_eq("arst_raddr",  32'(raddr), 0);
    check_eq("arst_rgray",  32'(rptr_gray), 0);
    wptr_gray = 8'h00;
    tick();
    rrst_n = 1'b1;
    repeat (3) tick();

    // 3-bit address instance: single push/pop rounds across the pointer MSB.
    wbin3 = '0; rbin3 = '0;
    for (int r = 0; r < 20; r++) begin
      wbin3 = wbin3 + 4'd1;
      wptr3 = g4(wbin3);
      repeat (3) tick();
      check_eq("wrap_rlevel", 32'(rlevel3), 1);
      prev_g = rptr_gray3;
      rinc3 = 1'b1;
      tick();
      rinc3 = 1'b0;
      rbin3 = rbin3 + 4'd1;
      check_eq("wrap_rgray",   32'(rptr_gray3), 32'(g4(rbin3)));
      check_eq("wrap_1bit",    32'($countones(prev_g ^ rptr_gray3)), 1);
      check_eq("wrap_rempty",  32'(rempty3), 1);
    end

    wbin3 = wbin3 + 4'd8;
    wptr3 = g4(wbin3);
    repeat (3) tick();
    check_eq("full_rlevel",  32'(rlevel3), 8);
    check_eq("full_rempty",  32'(rempty3), 0);
    check_eq("full_raempty", 32'(ralmost_empty3), 0);
    check_eq("full_raddr",   32'(raddr3), 32'(rbin3[2:0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
